// File: rtl/ula_pkg.sv
// ula_pkg: opcode type and MIPS-style ALU control codes shared by the ula files
package ula_pkg;
  typedef logic [3:0] op_t;
  localparam op_t ULA_AND = 4'b0000;
  localparam op_t ULA_OR  = 4'b0001;
  localparam op_t ULA_ADD = 4'b0010;
  localparam op_t ULA_SUB = 4'b0110;
  localparam op_t ULA_SLT = 4'b0111;
  localparam op_t ULA_NOR = 4'b1100;
endpackage

// File: rtl/ula_comb.sv
// ula_comb: combinational result/zero generator; overflow output only with ULA_OVERFLOW_EN
module ula_comb
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ULA_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  logic [WIDTH-1:0] sum, diff;
  logic             lt;
  assign sum  = a + b;
  assign diff = a - b;
  // true signed compare, immune to wrap of the difference
  assign lt   = $signed(a) < $signed(b);
  always_comb begin
    result = op == ULA_AND ? a & b :
             op == ULA_OR  ? a | b :
             op == ULA_ADD ? sum :
             op == ULA_SUB ? diff :
             op == ULA_SLT ? {{(WIDTH-1){1'b0}}, lt} :
             op == ULA_NOR ? ~(a | b) : '0;
    zero = ~|result;
  end
`ifdef ULA_OVERFLOW_EN
  always_comb
    overflow = op == ULA_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
               op == ULA_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
`endif
endmodule

// File: rtl/ula.sv
// ula: registered ALU with zero flag; define ULA_OVERFLOW_EN to add a registered overflow port
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       controladorULA,
  input  logic [WIDTH-1:0] dados1,
  input  logic [WIDTH-1:0] dados2,
  output logic [WIDTH-1:0] saida,
`ifdef ULA_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             zero
);
  logic [WIDTH-1:0] result;
  logic             result_zero;
`ifdef ULA_OVERFLOW_EN
  logic             result_ov;
`endif
  ula_comb #(.WIDTH(WIDTH)) u_comb (
    .op       (controladorULA),
    .a        (dados1),
    .b        (dados2),
`ifdef ULA_OVERFLOW_EN
    .overflow (result_ov),
`endif
    .result   (result),
    .zero     (result_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      saida <= '0;
      zero  <= 1'b1;
    end else begin
      saida <= result;
      zero  <= result_zero;
    end
`ifdef ULA_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= result_ov;
`endif
endmodule

// File: tb/tb_ula.sv
// tb_ula: scoreboard bench for ula; expectations queued at issue, checked by a monitor
module tb_ula;
  import ula_pkg::*;
  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ov;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ctl = 4'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] saida;
  logic        zero;
  logic        ov_out;
  exp_t        q[$];
  int          total = 0, bad = 0;
  ula #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .controladorULA (ctl),
    .dados1         (a),
    .dados2         (b),
    .saida          (saida),
`ifdef ULA_OVERFLOW_EN
    .overflow       (ov_out),
`endif
    .zero           (zero)
  );
`ifndef ULA_OVERFLOW_EN
  assign ov_out = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic apply(input string name, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] res, input logic ov);
    exp_t e;
    @(negedge clk);
    ctl = op;
    a = x;
    b = y;
    e.name = name;
    e.res = res;
    e.ov = ov;
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    #1;
    if (rst_n && q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.name, ".saida"}, saida, e.res);
      check({e.name, ".zero"}, {31'b0, zero}, {31'b0, e.res == 32'b0});
`ifdef ULA_OVERFLOW_EN
      check({e.name, ".ov"}, {31'b0, ov_out}, {31'b0, e.ov});
`endif
    end
  end
  initial begin
    exp_t e;
    ctl = ULA_ADD;
    a = 10;
    b = 15;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.saida", saida, 32'h0);
    check("rst.zero", {31'b0, zero}, 32'h1);
    check("rst.ov", {31'b0, ov_out}, 32'h0);
    rst_n = 1'b1;
    e.name = "rel_add";
    e.res = 25;
    e.ov = 1'b0;
    q.push_back(e);
    apply("sub",      ULA_SUB, 20, 5, 15, 1'b0);
    apply("sub_eq",   ULA_SUB, 7, 7, 0, 1'b0);
    apply("slt_lt",   ULA_SLT, 10, 15, 1, 1'b0);
    apply("slt_gt",   ULA_SLT, 15, 10, 0, 1'b0);
    apply("slt_neg",  ULA_SLT, 32'hFFFFFFFF, 1, 1, 1'b0);
    apply("slt_ovf",  ULA_SLT, 32'h7FFFFFFF, 32'h80000000, 0, 1'b0);
    apply("slt_ovf2", ULA_SLT, 32'h80000000, 32'h7FFFFFFF, 1, 1'b0);
    apply("and",      ULA_AND, 32'h20C, 32'h4C, 32'hC, 1'b0);
    apply("or",       ULA_OR, 32'h20C, 32'h4C, 32'h24C, 1'b0);
    apply("nor",      ULA_NOR, 0, 0, 32'hFFFFFFFF, 1'b0);
    apply("add_wrap", ULA_ADD, 32'h7FFFFFFF, 1, 32'h80000000, 1'b1);
    apply("sub_wrap", ULA_SUB, 0, 1, 32'hFFFFFFFF, 1'b0);
    apply("sub_ovf",  ULA_SUB, 32'h80000000, 1, 32'h7FFFFFFF, 1'b1);
    apply("add_carry", ULA_ADD, 32'hFFFFFFFF, 1, 0, 1'b0);
    apply("undef_f",  4'b1111, 5, 3, 0, 1'b0);
    apply("nor_mix",  ULA_NOR, 32'hF0F0F0F0, 32'h0000FFFF, 32'h0F0F0000, 1'b0);
    apply("undef_3",  4'b0011, 5, 3, 0, 1'b0);
    apply("pre_rst",  ULA_ADD, 10, 15, 25, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async.saida", saida, 32'h0);
    check("async.zero", {31'b0, zero}, 32'h1);
    check("async.ov", {31'b0, ov_out}, 32'h0);
    ctl = ULA_SUB;
    a = 9;
    b = 4;
    @(negedge clk);
    check("hold.saida", saida, 32'h0);
    rst_n = 1'b1;
    e.name = "post_rst";
    e.res = 5;
    e.ov = 1'b0;
    q.push_back(e);
    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
